spi_xfer_scheduler: RTL
=======================

SPI_XFER_SCHEDULER -- requirements
Module: spi_xfer_scheduler

Interface
REQ-001 SHALL have parameter CLKDIV, default 8'h14, baud divisor placed in CTRL[15:8].
REQ-002 SHALL have parameter TIMEOUT, default 16'hFFFF, max PCLK cycles waiting for eot_i.
REQ-003 SHALL have one clock; reset is asynchronous and active-low; ports are PCLK and PRSTN.
REQ-004 PCLK  in  1  clock, all logic on rising edge.
REQ-005 PRSTN  in  1  asynchronous active-low reset.
REQ-006 req_i  in  2  per-requester transfer request, bit i = requester i.
REQ-007 rw_i  in  2  per requester: 1 = SPI write (cmd 4'hB), 0 = SPI read (cmd 4'hA).
REQ-008 addr_i  in  8  4-bit SPI address per requester, [4i+3:4i].
REQ-009 len_i  in  12  6-bit data bit length per requester, [6i+5:6i], legal 1..32.
REQ-010 wdata_i  in  64  32-bit write data per requester, [32i+31:32i].
REQ-011 gnt_o  out  2  one-cycle grant pulse; request fields sampled that cycle.
REQ-012 done_o  out  2  one-cycle completion pulse to granted requester.
REQ-013 err_o  out  1  valid with done_o: PSLVERR, timeout or illegal len.
REQ-014 rdata_o  out  32  read result, valid with done_o of a read; holds until next done.
REQ-015 busy_o  out  1  high from grant until done pulse inclusive.
REQ-016 PADDR/PWRITE/PSEL/PENABLE/PWDATA  out  32/1/1/1/32  APB master to SPI master.
REQ-017 PRDATA/PREADY/PSLVERR  in  32/1/1  APB response.
REQ-018 eot_i  in  1  end-of-transfer from SPI master controller.

Function
REQ-019 States: IDLE, SETUP, ACCESS, GAP, WAIT_EOT, DONE; step counter selects register of current APB transfer.
REQ-020 Arbitration in IDLE only, round-robin: with both req_i high, grant the requester not served last; after reset requester 0 wins first.
REQ-021 Single request granted immediately; IDLE->grant->SETUP is one cycle; no grant while busy_o high.
REQ-022 req_i still high after its done_o is a new request.
REQ-023 len==0 at grant -> DONE next cycle, err_o=1, no APB traffic.
REQ-024 Write sequence (addr/data): 0x14={CLKDIV,8'h00}; 0x00=cmd; 0x04=addr zero-ext; 0x08=len zero-ext; 0x0C=wdata; 0x14={CLKDIV,8'h01}.
REQ-025 Read sequence: same without 0x0C write; after eot_i, APB read of 0x10, PRDATA captured to rdata_o.
REQ-026 Each APB transfer: SETUP 1 cycle (PSEL=1, PENABLE=0), ACCESS (PENABLE=1) until PREADY=1, then GAP 1 cycle with PSEL=0, PENABLE=0.
REQ-027 PADDR/PWRITE/PWDATA stable from SETUP through last ACCESS cycle; PWDATA=0 on reads.
REQ-028 PSLVERR=1 with PREADY=1 aborts the remaining steps -> DONE, err_o=1.
REQ-029 After start write, WAIT_EOT: eot_i sampled only here, incl. first cycle; eot_i outside WAIT_EOT ignored.
REQ-030 Write done: eot_i seen -> DONE next cycle; read: eot_i -> read transfer -> DONE.
REQ-031 Timeout counter counts WAIT_EOT cycles; reaching TIMEOUT -> DONE, err_o=1, no RDATA read.
REQ-032 DONE lasts 1 cycle: done_o[granted]=1, then IDLE.

Reset
REQ-033 PRSTN low, at any time incl. mid-transfer: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, gnt_o=0, done_o=0, err_o=0, busy_o=0, rdata_o=0, RR pointer favours requester 0, timeout counter 0.
REQ-034 No done_o for a transfer interrupted by reset.

Verification
REQ-035 Req0 write, addr 3, len 16, wdata 0x1111, PREADY=1, eot_i 50 cycles after start -> 6 transfers at 3 cycles each with data 0x1400,0xB,0x3,0x10,0x1111,0x1401; done_o[0] one cycle after eot_i, err_o=0.
REQ-036 Req1 read, len 16, PRDATA=0xF00F -> 5 writes (no 0x0C), read of 0x10, rdata_o=0x0000F00F with done_o[1].
REQ-037 Both req_i high continuously -> grants alternate 0,1,0,1.
REQ-038 PREADY low 3 cycles on CMD write -> ACCESS held 4 cycles, signals stable; PSLVERR=1 on ADDR write -> no further transfers, done_o with err_o=1.
REQ-039 eot_i never asserted, TIMEOUT=100 -> done_o and err_o=1 exactly 100 cycles after WAIT_EOT entry; len=0 -> done_o+err_o without PSEL.
REQ-040 PRSTN low during ACCESS -> PSEL/PENABLE low immediately, no done_o; next request after release granted to requester 0.

Source files
------------

// File: rtl/spi_xfer_scheduler.sv
// Two-requester scheduler that turns SPI transfer requests into APB register
// sequences for an SPI master controller and reports completion per requester.
module spi_xfer_scheduler #(
    parameter logic [7:0]  CLKDIV  = 8'h14,
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic        PCLK,
    input  logic        PRSTN,
    input  logic [1:0]  req_i,
    input  logic [1:0]  rw_i,
    input  logic [7:0]  addr_i,
    input  logic [11:0] len_i,
    input  logic [63:0] wdata_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic        PSEL,
    output logic        PENABLE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    input  logic        eot_i
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        ACCESS   = 3'd2,
        GAP      = 3'd3,
        WAIT_EOT = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [2:0] STEP_DIV   = 3'd0;
    localparam logic [2:0] STEP_CMD   = 3'd1;
    localparam logic [2:0] STEP_ADDR  = 3'd2;
    localparam logic [2:0] STEP_LEN   = 3'd3;
    localparam logic [2:0] STEP_DATA  = 3'd4;
    localparam logic [2:0] STEP_START = 3'd5;
    localparam logic [2:0] STEP_RDATA = 3'd6;

    state_t      state_r, state_s;
    logic [2:0]  step_r, step_s;
    logic        cur_r, cur_s;
    logic        rw_r, rw_s;
    logic [3:0]  addr_r, addr_s;
    logic [5:0]  len_r, len_s;
    logic [31:0] wdata_r, wdata_s;
    logic        err_r, err_s;
    logic        prio_r, prio_s;
    logic [15:0] tmo_r, tmo_s;
    logic [31:0] rbuf_r, rbuf_s;
    logic [1:0]  gnt_s;
    logic        g_s;

    function automatic logic [31:0] step_addr(input logic [2:0] step);
        case (step)
            STEP_DIV:   step_addr = 32'h0000_0014;
            STEP_CMD:   step_addr = 32'h0000_0000;
            STEP_ADDR:  step_addr = 32'h0000_0004;
            STEP_LEN:   step_addr = 32'h0000_0008;
            STEP_DATA:  step_addr = 32'h0000_000C;
            STEP_START: step_addr = 32'h0000_0014;
            STEP_RDATA: step_addr = 32'h0000_0010;
            default:    step_addr = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] step_wdata(input logic [2:0] step, input logic rw,
                                               input logic [3:0] addr, input logic [5:0] len,
                                               input logic [31:0] wdata);
        case (step)
            STEP_DIV:   step_wdata = {16'h0000, CLKDIV, 8'h00};
            STEP_CMD:   step_wdata = rw ? 32'h0000_000B : 32'h0000_000A;
            STEP_ADDR:  step_wdata = {28'h000_0000, addr};
            STEP_LEN:   step_wdata = {26'h000_0000, len};
            STEP_DATA:  step_wdata = wdata;
            STEP_START: step_wdata = {16'h0000, CLKDIV, 8'h01};
            default:    step_wdata = 32'h0000_0000;
        endcase
    endfunction

    // Next-state, arbitration and transfer bookkeeping
    always_comb begin
        state_s = state_r;
        step_s  = step_r;
        cur_s   = cur_r;
        rw_s    = rw_r;
        addr_s  = addr_r;
        len_s   = len_r;
        wdata_s = wdata_r;
        err_s   = err_r;
        prio_s  = prio_r;
        tmo_s   = tmo_r;
        rbuf_s  = rbuf_r;
        gnt_s   = 2'b00;
        g_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_i != 2'b00) begin
                    // prio_r names the requester that wins a tie
                    if (req_i == 2'b11) begin
                        g_s = prio_r;
                    end else begin
                        g_s = req_i[1];
                    end
                    cur_s   = g_s;
                    prio_s  = ~g_s;
                    gnt_s   = g_s ? 2'b10 : 2'b01;
                    rw_s    = rw_i[g_s];
                    addr_s  = g_s ? addr_i[7:4] : addr_i[3:0];
                    len_s   = g_s ? len_i[11:6] : len_i[5:0];
                    wdata_s = g_s ? wdata_i[63:32] : wdata_i[31:0];
                    step_s  = STEP_DIV;
                    tmo_s   = 16'd0;
                    // Illegal length parks in GAP (bus idle) so DONE follows the grant cycle
                    if ((len_s == 6'd0) || (len_s > 6'd32)) begin
                        err_s   = 1'b1;
                        state_s = GAP;
                    end else begin
                        err_s   = 1'b0;
                        state_s = SETUP;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                state_s = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        err_s   = 1'b1;
                        state_s = DONE;
                    end else begin
                        if (step_r == STEP_RDATA) begin
                            rbuf_s = PRDATA;
                        end else begin
                            rbuf_s = rbuf_r;
                        end
                        state_s = GAP;
                    end
                end else begin
                    state_s = ACCESS;
                end
            end
            GAP: begin
                if (err_r) begin
                    state_s = DONE;
                end else if (step_r == STEP_START) begin
                    tmo_s   = 16'd0;
                    state_s = WAIT_EOT;
                end else if (step_r == STEP_RDATA) begin
                    state_s = DONE;
                end else begin
                    state_s = SETUP;
                    if ((step_r == STEP_LEN) && !rw_r) begin
                        step_s = STEP_START;
                    end else begin
                        step_s = step_r + 3'd1;
                    end
                end
            end
            WAIT_EOT: begin
                if (eot_i) begin
                    tmo_s = 16'd0;
                    if (rw_r) begin
                        state_s = DONE;
                    end else begin
                        step_s  = STEP_RDATA;
                        state_s = SETUP;
                    end
                end else if (({1'b0, tmo_r} + 17'd1) >= {1'b0, TIMEOUT}) begin
                    tmo_s   = 16'd0;
                    err_s   = 1'b1;
                    state_s = DONE;
                end else begin
                    tmo_s = tmo_r + 16'd1;
                end
            end
            DONE: begin
                err_s   = 1'b0;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Internal state registers
    always_ff @(posedge PCLK or negedge PRSTN) begin
        if (!PRSTN) begin
            state_r <= IDLE;
            step_r  <= STEP_DIV;
            cur_r   <= 1'b0;
            rw_r    <= 1'b0;
            addr_r  <= 4'h0;
            len_r   <= 6'd0;
            wdata_r <= 32'h0000_0000;
            err_r   <= 1'b0;
            prio_r  <= 1'b0;
            tmo_r   <= 16'd0;
            rbuf_r  <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            step_r  <= step_s;
            cur_r   <= cur_s;
            rw_r    <= rw_s;
            addr_r  <= addr_s;
            len_r   <= len_s;
            wdata_r <= wdata_s;
            err_r   <= err_s;
            prio_r  <= prio_s;
            tmo_r   <= tmo_s;
            rbuf_r  <= rbuf_s;
        end
    end

    // Registered outputs, decoded from the upcoming state
    always_ff @(posedge PCLK or negedge PRSTN) begin
        if (!PRSTN) begin
            gnt_o   <= 2'b00;
            done_o  <= 2'b00;
            err_o   <= 1'b0;
            busy_o  <= 1'b0;
            rdata_o <= 32'h0000_0000;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= 32'h0000_0000;
            PWDATA  <= 32'h0000_0000;
        end else begin
            gnt_o   <= gnt_s;
            done_o  <= (state_s == DONE) ? (cur_s ? 2'b10 : 2'b01) : 2'b00;
            err_o   <= (state_s == DONE) && err_s;
            busy_o  <= (state_s != IDLE);
            PSEL    <= (state_s == SETUP) || (state_s == ACCESS);
            PENABLE <= (state_s == ACCESS);
            // Address/data only change on entry to SETUP, so they hold through ACCESS
            if (state_s == SETUP) begin
                PADDR  <= step_addr(step_s);
                PWRITE <= (step_s != STEP_RDATA);
                PWDATA <= step_wdata(step_s, rw_s, addr_s, len_s, wdata_s);
            end
            if ((state_s == DONE) && !err_s && !rw_s) begin
                rdata_o <= rbuf_s;
            end
        end
    end

endmodule
